// File: rtl/accum_scheduler.sv
// accum_scheduler
//   Shares one fixed-length accumulate engine among NREQ requesters with a
//   round-robin arbiter. A granted requester streams LEN samples on its own
//   lane; the zero-extended samples are summed modulo 2^SUM_W and returned
//   with the requester index.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   req          per-requester request, held until ack
//   data_in      packed sample lanes, lane i = [i*DATA_W +: DATA_W]
//   data_valid   per-lane sample valid
//   grant        one-hot owner of the engine (ACCUM only)
//   ack          one-cycle pulse to the requester whose job completed
//   result_valid one-cycle pulse, result fields valid
//   result_sum   completed sum, held until the next result
//   result_id    requester index of the result, held
//   abort        one-cycle pulse when the granted requester drops req
//   busy         high while in ACCUM or DONE
module accum_scheduler #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16,
  parameter int LEN    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DATA_W-1:0]  data_in,
  input  logic [NREQ-1:0]         data_valid,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic                    result_valid,
  output logic [SUM_W-1:0]        result_sum,
  output logic [$clog2(NREQ)-1:0] result_id,
  output logic                    abort,
  output logic                    busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              result_valid_q, result_valid_d;
  logic [SUM_W-1:0]  result_sum_q, result_sum_d;
  logic [ID_W-1:0]   result_id_q, result_id_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;

  // Unpack the lanes so the granted one can be selected by index.
  logic [DATA_W-1:0] lane [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign lane[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  logic [SUM_W-1:0] sum_next;
  assign sum_next = acc_q + SUM_W'(lane[id_q]);

  function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] i);
    return NREQ'(1) << i;
  endfunction

  // Round-robin pick: first set req bit searching upward from last_id+1
  // with wrap. Scanning from the farthest offset down lets the nearest
  // candidate overwrite the others.
  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] idx;
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_id_q) + k) % NREQ);
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    last_id_d      = last_id_q;
    acc_d          = acc_q;
    count_d        = count_q;
    grant_d        = '0;
    ack_d          = '0;
    result_valid_d = 1'b0;
    result_sum_d   = result_sum_q;
    result_id_d    = result_id_q;
    abort_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          id_d    = pick_id;
          acc_d   = '0;
          count_d = '0;
          grant_d = onehot(pick_id);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (!req[id_q]) begin
          // Requester withdrew: any sample this cycle is dropped.
          abort_d   = 1'b1;
          last_id_d = id_q;
          state_d   = IDLE;
        end else if (data_valid[id_q] && count_q == CNT_W'(LEN - 1)) begin
          // Final sample: publish the result so it is visible in DONE.
          acc_d          = sum_next;
          count_d        = count_q + CNT_W'(1);
          result_valid_d = 1'b1;
          ack_d          = onehot(id_q);
          result_sum_d   = sum_next;
          result_id_d    = id_q;
          last_id_d      = id_q;
          state_d        = DONE;
        end else begin
          grant_d = onehot(id_q);
          if (data_valid[id_q]) begin
            acc_d   = sum_next;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      id_q           <= '0;
      last_id_q      <= ID_W'(NREQ - 1);
      acc_q          <= '0;
      count_q        <= '0;
      grant_q        <= '0;
      ack_q          <= '0;
      result_valid_q <= 1'b0;
      result_sum_q   <= '0;
      result_id_q    <= '0;
      abort_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      last_id_q      <= last_id_d;
      acc_q          <= acc_d;
      count_q        <= count_d;
      grant_q        <= grant_d;
      ack_q          <= ack_d;
      result_valid_q <= result_valid_d;
      result_sum_q   <= result_sum_d;
      result_id_q    <= result_id_d;
      abort_q        <= abort_d;
      busy_q         <= busy_d;
    end
  end

  assign grant        = grant_q;
  assign ack          = ack_q;
  assign result_valid = result_valid_q;
  assign result_sum   = result_sum_q;
  assign result_id    = result_id_q;
  assign abort        = abort_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_accum_scheduler.sv
// Testbench for accum_scheduler: scenario tasks with randomized lanes,
// checked against a job-level model (round-robin pick rule, summed samples).
module tb_accum_scheduler;
  localparam int NREQ = 4;
  localparam int LEN  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req, data_valid, grant, ack;
  logic [31:0] data_in;
  logic        result_valid, abort, busy;
  logic [15:0] result_sum;
  logic [1:0]  result_id;

  logic [3:0]  req8, data_valid8, grant8, ack8;
  logic [31:0] data_in8;
  logic        result_valid8, abort8, busy8;
  logic [7:0]  result_sum8;
  logic [1:0]  result_id8;

  accum_scheduler #(.NREQ(4), .DATA_W(8), .SUM_W(16), .LEN(LEN)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .data_valid(data_valid), .grant(grant), .ack(ack),
    .result_valid(result_valid), .result_sum(result_sum),
    .result_id(result_id), .abort(abort), .busy(busy)
  );

  accum_scheduler #(.NREQ(4), .DATA_W(8), .SUM_W(8), .LEN(LEN)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .data_in(data_in8),
    .data_valid(data_valid8), .grant(grant8), .ack(ack8),
    .result_valid(result_valid8), .result_sum(result_sum8),
    .result_id(result_id8), .abort(abort8), .busy(busy8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Job-level model state
  int          exp_last;
  logic [15:0] exp_rsum;
  logic [1:0]  exp_rid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] m, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req = '0; data_valid = '0; data_in = '0;
    req8 = '0; data_valid8 = '0; data_in8 = '0;
    tick();
    tick();
    reset = 1'b0;
    exp_last = NREQ - 1;
    exp_rsum = '0;
    exp_rid  = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({grant, ack, abort, result_valid, busy, result_sum, result_id} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b ack=%b abort=%b rv=%b busy=%b sum=%0d id=%0d want all 0",
               grant, ack, abort, result_valid, busy, result_sum, result_id);
    end
    n_checks++;
    if ({grant8, ack8, abort8, result_valid8, busy8, result_sum8, result_id8} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs8: got grant=%b rv=%b busy=%b sum=%0d want all 0",
               grant8, result_valid8, busy8, result_sum8);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_no_req: got busy=%b grant=%b want 0 0000", busy, grant);
    end
    $display("reset done");
  endtask

  task automatic test_single_job();
    logic [15:0] s = '0;
    req = 4'b0001; data_valid = 4'b0001; data_in = '0; data_in[7:0] = 8'd1;
    tick();
    for (int k = 0; k < LEN; k++) begin
      data_in[7:0] = 8'(k + 1);
      s += 16'(k + 1);
      n_checks++;
      if (grant !== 4'b0001 || result_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_accum[%0d]: got grant=%b rv=%b busy=%b want 0001 0 1", k, grant, result_valid, busy);
      end
      tick();
    end
    n_checks++;
    if (result_valid !== 1'b1 || ack !== 4'b0001 || result_sum !== s || result_id !== 2'd0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_result: got rv=%b ack=%b sum=%0d id=%0d grant=%b want 1 0001 %0d 0 0000",
               result_valid, ack, result_sum, result_id, grant, s);
    end
    exp_last = 0; exp_rsum = s; exp_rid = 2'd0;
    tick();
    req = '0; data_valid = '0;
    n_checks++;
    if (result_valid !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || result_sum !== exp_rsum) begin
      n_fail++;
      $display("FAIL single_after: got rv=%b ack=%b busy=%b sum=%0d want 0 0000 0 %0d",
               result_valid, ack, busy, result_sum, exp_rsum);
    end
    $display("single job lane=0 sum=%0d", s);
  endtask

  task automatic test_round_robin();
    int cyc = 0;
    int last_cyc = 0;
    int w;
    do_reset();
    req = 4'b1111; data_valid = 4'b1111; data_in = {4{8'd10}};
    for (int j = 0; j < 5; j++) begin
      int start;
      w = pick(4'b1111, exp_last);
      start = cyc;
      while (result_valid !== 1'b1 && cyc - start < 40) begin
        tick();
        cyc++;
        if (grant !== 4'b0000) begin
          n_checks++;
          if (grant !== 4'(1 << w)) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: got %b want %b", j, grant, 4'(1 << w));
          end
        end
      end
      n_checks++;
      if (result_valid !== 1'b1 || result_id !== 2'(w) || result_sum !== 16'd50 || ack !== 4'(1 << w)) begin
        n_fail++;
        $display("FAIL rr_result[%0d]: got rv=%b id=%0d sum=%0d ack=%b want 1 %0d 50 %b",
                 j, result_valid, result_id, result_sum, ack, w, 4'(1 << w));
      end
      n_checks++;
      if (cyc - last_cyc !== ((j == 0) ? LEN + 1 : LEN + 2)) begin
        n_fail++;
        $display("FAIL rr_spacing[%0d]: got %0d cycles want %0d", j, cyc - last_cyc, (j == 0) ? LEN + 1 : LEN + 2);
      end
      $display("rr job %0d id=%0d sum=%0d at cycle %0d", j, result_id, result_sum, cyc);
      last_cyc = cyc;
      exp_last = w; exp_rsum = 16'd50; exp_rid = 2'(w);
      tick();
      cyc++;
    end
    req = '0; data_valid = '0;
    tick();
  endtask

  task automatic test_valid_gaps();
    logic [7:0] pat = 8'b1101_1001;
    req = 4'b0100;
    data_in = $urandom; data_in[23:16] = 8'd7;
    data_valid = 4'($urandom); data_valid[2] = pat[0];
    tick();
    for (int c = 0; c < 8; c++) begin
      data_in = $urandom; data_in[23:16] = 8'd7;
      data_valid = 4'($urandom); data_valid[2] = pat[c];
      n_checks++;
      if (grant !== 4'b0100 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL gaps_accum[%0d]: got grant=%b rv=%b want 0100 0", c, grant, result_valid);
      end
      tick();
    end
    n_checks++;
    if (result_valid !== 1'b1 || result_sum !== 16'd35 || result_id !== 2'd2 || ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL gaps_result: got rv=%b sum=%0d id=%0d ack=%b want 1 35 2 0100",
               result_valid, result_sum, result_id, ack);
    end
    exp_last = 2; exp_rsum = 16'd35; exp_rid = 2'd2;
    tick();
    req = '0; data_valid = '0;
    $display("gap job lane=2 sum=%0d", result_sum);
  endtask

  task automatic test_wrap();
    logic [7:0] e = 8'((LEN * 255) % 256);
    req8 = 4'b0010; data_valid8 = 4'b0010; data_in8 = '0; data_in8[15:8] = 8'd255;
    tick();
    for (int k = 0; k < LEN; k++) begin
      n_checks++;
      if (grant8 !== 4'b0010) begin
        n_fail++;
        $display("FAIL wrap_grant[%0d]: got %b want 0010", k, grant8);
      end
      tick();
    end
    n_checks++;
    if (result_valid8 !== 1'b1 || result_sum8 !== e || result_id8 !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_result: got rv=%b sum=%0d id=%0d want 1 %0d 1", result_valid8, result_sum8, result_id8, e);
    end
    tick();
    req8 = '0; data_valid8 = '0;
    $display("wrap job lane=1 sum=%0d", result_sum8);
  endtask

  task automatic test_abort();
    logic [15:0] s = '0;
    req = 4'b1000; data_valid = 4'b1000; data_in = $urandom;
    tick();
    n_checks++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_grant: got %b want 1000", grant);
    end
    for (int k = 0; k < 2; k++) begin
      data_in = $urandom;
      tick();
    end
    req = 4'b0010; data_valid = 4'b1010; data_in = $urandom;
    tick();
    n_checks++;
    if (abort !== 1'b1 || grant !== 4'b0000 || result_valid !== 1'b0 || ack !== 4'b0000 || result_sum !== exp_rsum) begin
      n_fail++;
      $display("FAIL abort_pulse: got abort=%b grant=%b rv=%b ack=%b sum=%0d want 1 0000 0 0000 %0d",
               abort, grant, result_valid, ack, result_sum, exp_rsum);
    end
    exp_last = 3;
    tick();
    n_checks++;
    if (abort !== 1'b0 || grant !== 4'(1 << pick(4'b0010, exp_last))) begin
      n_fail++;
      $display("FAIL abort_next_grant: got abort=%b grant=%b want 0 0010", abort, grant);
    end
    for (int k = 0; k < LEN; k++) begin
      data_in = $urandom; data_valid = 4'b0010;
      s += 16'(data_in[15:8]);
      tick();
    end
    n_checks++;
    if (result_valid !== 1'b1 || result_sum !== s || result_id !== 2'd1) begin
      n_fail++;
      $display("FAIL abort_followup: got rv=%b sum=%0d id=%0d want 1 %0d 1", result_valid, result_sum, result_id, s);
    end
    exp_last = 1; exp_rsum = s; exp_rid = 2'd1;
    tick();
    req = '0; data_valid = '0;
    $display("abort lane=3, follow-up lane=1 sum=%0d", s);
  endtask

  task automatic test_reset_mid_job();
    logic [15:0] s = '0;
    req = 4'b0010; data_valid = 4'b0010; data_in = {4{8'd200}};
    tick();
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({grant, ack, abort, result_valid, busy, result_sum, result_id} !== 29'd0) begin
      n_fail++;
      $display("FAIL midjob_reset: got grant=%b ack=%b abort=%b rv=%b busy=%b sum=%0d id=%0d want all 0",
               grant, ack, abort, result_valid, busy, result_sum, result_id);
    end
    reset = 1'b0;
    exp_last = NREQ - 1;
    tick();
    n_checks++;
    if (grant !== 4'(1 << pick(4'b0010, exp_last))) begin
      n_fail++;
      $display("FAIL midjob_regrant: got %b want 0010", grant);
    end
    for (int k = 0; k < LEN; k++) begin
      data_in = $urandom; data_valid = 4'b0010;
      s += 16'(data_in[15:8]);
      tick();
    end
    n_checks++;
    if (result_valid !== 1'b1 || result_sum !== s || result_id !== 2'd1) begin
      n_fail++;
      $display("FAIL midjob_fresh: got rv=%b sum=%0d id=%0d want 1 %0d 1", result_valid, result_sum, result_id, s);
    end
    exp_last = 1; exp_rsum = s; exp_rid = 2'd1;
    tick();
    req = '0; data_valid = '0;
    $display("reset mid-job, fresh lane=1 sum=%0d", s);
  endtask

  task automatic test_back_to_back(input int njobs);
    for (int j = 0; j < njobs; j++) begin
      logic [3:0]  m;
      logic [15:0] s;
      int w, n, cyc;
      m = 4'($urandom_range(15, 1));
      w = pick(m, exp_last);
      req = m; data_in = $urandom; data_valid = 4'($urandom);
      data_valid[w] = ($urandom_range(3) != 0);
      tick();
      s = '0; n = 0; cyc = 0;
      while (n < LEN && cyc < 100) begin
        if (cyc > 0) begin
          data_in = $urandom; data_valid = 4'($urandom);
          data_valid[w] = ($urandom_range(3) != 0);
        end
        if (data_valid[w]) begin
          s += 16'(data_in[w*8 +: 8]);
          n++;
        end
        n_checks++;
        if (grant !== 4'(1 << w) || result_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_accum[%0d]: got grant=%b rv=%b want %b 0", j, grant, result_valid, 4'(1 << w));
        end
        tick();
        cyc++;
      end
      n_checks++;
      if (result_valid !== 1'b1 || ack !== 4'(1 << w) || result_sum !== s || result_id !== 2'(w) || grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got rv=%b ack=%b sum=%0d id=%0d grant=%b want 1 %b %0d %0d 0000",
                 j, result_valid, ack, result_sum, result_id, grant, 4'(1 << w), s, w);
      end
      exp_last = w; exp_rsum = s; exp_rid = 2'(w);
      $display("b2b job %0d req=%b id=%0d sum=%0d", j, m, w, s);
      tick();
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || result_sum !== exp_rsum || result_id !== exp_rid) begin
        n_fail++;
        $display("FAIL b2b_idle[%0d]: got rv=%b busy=%b sum=%0d id=%0d want 0 0 %0d %0d",
                 j, result_valid, busy, result_sum, result_id, exp_rsum, exp_rid);
      end
    end
    req = '0; data_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_valid_gaps();
    test_wrap();
    test_abort();
    test_reset_mid_job();
    test_back_to_back(25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
